// File: rtl/dsp_pkg.sv
// Shared word-format constants and FSM state encoding for the DSP front end.
// Latency: none, declarations only.
// Backpressure: not applicable.
package dsp_pkg;

    localparam int DSP_WORD_W  = 14;
    localparam int DSP_SOF_BIT = 13;
    localparam int DSP_OVF_BIT = 12;
    localparam int DSP_DATA_W  = 12;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } dsp_state_e;

endpackage

// File: rtl/dsp_rr_arbiter.sv
// Round-robin pick: first asserted request at or after i_ptr, ascending with wrap.
// Latency: combinational.
// Backpressure: none; the caller decides when a pick is taken.
module dsp_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic [CH_W-1:0]   o_gnt_idx,
    output logic              o_gnt_any
);

    // Scan channels starting at the pointer; the first hit wins.
    always_comb begin
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!o_gnt_any && i_req[(int'(i_ptr) + i) % NUM_CH]) begin
                o_gnt_any = 1'b1;
                o_gnt_idx = CH_W'((int'(i_ptr) + i) % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/dsp_rect_arbiter.sv
// Packet-granular round-robin mux of NUM_CH ADC channels onto one rectifier input.
// Latency: 1 cycle from accepted word to o_data; o_chan_rect trails o_chan by RECT_LAT.
// Backpressure: only the granted channel sees ready; the rectifier side never stalls.
module dsp_rect_arbiter
    import dsp_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int PKT_LEN  = 16,
    parameter int TIMEOUT  = 64,
    parameter int RECT_LAT = 1,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic [DSP_WORD_W*NUM_CH-1:0] i_data,
    input  logic [NUM_CH-1:0]            i_valid,
    output logic [NUM_CH-1:0]            o_ready,
    output logic [DSP_WORD_W-1:0]        o_data,
    output logic                         o_valid,
    output logic [CH_W-1:0]              o_chan,
    output logic [CH_W-1:0]              o_chan_rect,
    output logic                         o_busy,
    output logic                         o_err,
    output logic                         o_timeout
);

    localparam int WCNT_W = $clog2(PKT_LEN);
    localparam int ICNT_W = $clog2(TIMEOUT);

    dsp_state_e             r_state;
    logic [CH_W-1:0]        r_grant;
    logic [CH_W-1:0]        r_ptr;
    logic [WCNT_W-1:0]      r_wcnt;
    logic [ICNT_W-1:0]      r_icnt;
    logic [CH_W-1:0]        r_tag [RECT_LAT];

    logic [DSP_WORD_W-1:0]  w_ch_dat [NUM_CH];
    logic [NUM_CH-1:0]      w_req;
    logic [NUM_CH-1:0]      w_drop;
    logic [NUM_CH-1:0]      w_onehot;
    logic [CH_W-1:0]        w_gnt_idx;
    logic                   w_gnt_any;
    logic [CH_W-1:0]        w_ptr_nxt;
    logic [DSP_WORD_W-1:0]  w_sel_dat;
    logic                   w_xfer;

    // Split the flat input bus and classify each channel as SoF request or stray word.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            w_ch_dat[k] = i_data[DSP_WORD_W*k +: DSP_WORD_W];
            w_req[k]    = i_valid[k] &&  w_ch_dat[k][DSP_SOF_BIT];
            w_drop[k]   = i_valid[k] && !w_ch_dat[k][DSP_SOF_BIT];
        end
    end

    dsp_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr (
        .i_req     (w_req),
        .i_ptr     (r_ptr),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_any (w_gnt_any)
    );

    assign w_ptr_nxt = (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_onehot  = {{(NUM_CH-1){1'b0}}, 1'b1} << r_grant;
    assign w_sel_dat = w_ch_dat[r_grant];
    assign w_xfer    = (r_state == ST_GRANT) && i_valid[r_grant];
    assign o_busy    = (r_state == ST_GRANT);

    // Ready: granted channel only while busy; stray non-SoF words are swallowed while idle.
    always_comb begin
        o_ready = '0;
        if (i_rstn) begin
            if (r_state == ST_GRANT) o_ready = w_onehot;
            else                     o_ready = w_drop;
        end
    end

    // Grant FSM with word/idle counters and the registered output word.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_ptr     <= '0;
            r_wcnt    <= '0;
            r_icnt    <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_chan    <= '0;
            o_err     <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_valid   <= 1'b0;
            o_err     <= 1'b0;
            o_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_wcnt <= '0;
                    r_icnt <= '0;
                    if (|w_drop) o_err <= 1'b1;
                    if (w_gnt_any) begin
                        r_grant <= w_gnt_idx;
                        r_ptr   <= w_ptr_nxt;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_xfer) begin
                        r_icnt  <= '0;
                        o_valid <= 1'b1;
                        o_data  <= w_sel_dat;
                        o_chan  <= r_grant;
                        // A SoF inside a packet resyncs the count, even on the last slot.
                        if (w_sel_dat[DSP_SOF_BIT] && (r_wcnt != '0)) begin
                            r_wcnt <= WCNT_W'(1);
                            o_err  <= 1'b1;
                        end else if (r_wcnt == WCNT_W'(PKT_LEN - 1)) begin
                            r_wcnt  <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end else if (r_icnt == ICNT_W'(TIMEOUT - 1)) begin
                        r_icnt    <= '0;
                        r_wcnt    <= '0;
                        o_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_icnt <= r_icnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Channel tag pipeline matching the rectifier latency; shifts every cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            for (int i = 0; i < RECT_LAT; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= o_chan;
            for (int i = 1; i < RECT_LAT; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    assign o_chan_rect = r_tag[RECT_LAT-1];

endmodule

// File: tb/tb_dsp_rect_arbiter.sv
// Scoreboard bench for dsp_rect_arbiter with a small rectifier model on the output.
// Latency: checks word order, 2-cycle first-word timing, bubbles, timeout and reset.
// Backpressure: per-channel sources hold each word until ready, idle entries insert stalls.
module tb_dsp_rect_arbiter;

    localparam int NUM_CH   = 4;
    localparam int PKT_LEN  = 16;
    localparam int TIMEOUT  = 64;
    localparam int RECT_LAT = 1;
    localparam int CH_W     = 2;

    typedef struct packed {
        logic [CH_W-1:0] chan;
        logic [13:0]     dat;
    } exp_t;

    logic                   i_clk = 1'b0;
    logic                   i_rstn = 1'b0;
    logic [14*NUM_CH-1:0]   i_data = '0;
    logic [NUM_CH-1:0]      i_valid = '0;
    logic [NUM_CH-1:0]      o_ready;
    logic [13:0]            o_data;
    logic                   o_valid;
    logic [CH_W-1:0]        o_chan;
    logic [CH_W-1:0]        o_chan_rect;
    logic                   o_busy;
    logic                   o_err;
    logic                   o_timeout;

    logic [14:0] src_q [NUM_CH][$];
    exp_t        exp_q [$];
    exp_t        pend;
    bit          pend_vld;
    logic [13:0] r_rect;

    int n_chk = 0, n_fail = 0;
    int first_vld, last_vld, n_vld, n_err_p, n_to_p, to_iter;
    bit first_busy, last_busy, gap_chk;

    dsp_rect_arbiter #(
        .NUM_CH   (NUM_CH),
        .PKT_LEN  (PKT_LEN),
        .TIMEOUT  (TIMEOUT),
        .RECT_LAT (RECT_LAT)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_chan      (o_chan),
        .o_chan_rect (o_chan_rect),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .o_timeout   (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [13:0] rect_fn(input logic [13:0] w);
        logic [11:0] d;
        d = w[11:0];
        if (d[11]) d = -d;
        return {w[13:12], d};
    endfunction

    // Rectifier stand-in with one cycle of latency.
    always @(posedge i_clk) r_rect <= rect_fn(o_data);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, want);
        end
    endtask

    task automatic add_word(input int ch, input logic [13:0] w, input bit keep);
        src_q[ch].push_back({1'b0, w});
        if (keep) exp_q.push_back({CH_W'(ch), w});
    endtask

    task automatic add_idle(input int ch, input int n);
        for (int i = 0; i < n; i++) src_q[ch].push_back(15'h4000);
    endtask

    task automatic add_pkt(input int ch, input int n, input int base, input int n_keep);
        logic [13:0] w;
        for (int i = 0; i < n; i++) begin
            w = {(i == 0), 1'b0, 12'(base + i)};
            add_word(ch, w, i < n_keep);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NUM_CH; k++) begin
            if (src_q[k].size() > 0 && !src_q[k][0][14]) begin
                i_valid[k]       = 1'b1;
                i_data[14*k +: 14] = src_q[k][0][13:0];
            end else begin
                i_valid[k]       = 1'b0;
                i_data[14*k +: 14] = 14'h0;
            end
        end
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        for (int k = 0; k < NUM_CH; k++) src_q[k].delete();
        exp_q.delete();
        drive();
        pend_vld = 0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rstn    = 1'b1;
        first_vld = -1;
        last_vld  = -1;
        n_vld     = 0;
        n_err_p   = 0;
        n_to_p    = 0;
        to_iter   = -1;
        gap_chk   = 0;
    endtask

    task automatic run(input int n);
        logic [NUM_CH-1:0] acc;
        exp_t e;
        for (int c = 1; c <= n; c++) begin
            @(negedge i_clk);
            acc = i_valid & o_ready;
            @(posedge i_clk);
            #1;
            if (pend_vld) begin
                check("chan_rect", o_chan_rect, pend.chan);
                check("rect_out", r_rect, rect_fn(pend.dat));
            end
            pend_vld = 0;
            if (o_valid) begin
                if (first_vld < 0) begin
                    first_vld  = c;
                    first_busy = o_busy;
                end
                if (gap_chk && last_vld >= 0 && c - last_vld > 1) check("gap", c - last_vld - 1, 1);
                last_vld  = c;
                last_busy = o_busy;
                n_vld++;
                if (exp_q.size() == 0) begin
                    check("extra_vld", o_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("word", {o_chan, o_data}, e);
                    pend     = e;
                    pend_vld = 1;
                end
            end
            n_err_p += int'(o_err);
            n_to_p  += int'(o_timeout);
            if (o_timeout) begin
                to_iter = c;
                check("to_busy", o_busy, 1'b0);
            end
            for (int k = 0; k < NUM_CH; k++)
                if (src_q[k].size() > 0 && (acc[k] || src_q[k][0][14])) void'(src_q[k].pop_front());
            drive();
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", o_valid, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_data", o_data, 14'h0);
        check("rst_chan_rect", o_chan_rect, 2'd0);
        check("rst_ready", o_ready, 4'h0);

        // Single channel packet
        do_reset();
        add_pkt(2, 16, 1, 16);
        drive();
        run(24);
        check("s_first", first_vld, 2);
        check("s_nvld", n_vld, 16);
        check("s_span", last_vld - first_vld, 15);
        check("s_busy_first", first_busy, 1'b1);
        check("s_busy_last", last_busy, 1'b0);
        check("s_left", exp_q.size(), 0);

        // Contention: grant order 0,1,3,0 with one bubble between packets
        do_reset();
        gap_chk = 1;
        add_pkt(0, 16, 12'h000, 16);
        add_pkt(1, 16, 12'h100, 16);
        add_pkt(3, 16, 12'h300, 16);
        add_pkt(0, 16, 12'h040, 16);
        drive();
        run(80);
        check("c_nvld", n_vld, 64);
        check("c_left", exp_q.size(), 0);
        check("c_err", n_err_p, 0);

        // Stall of 64 cycles aborts ch1, then ch2 gets the grant
        do_reset();
        add_pkt(1, 6, 12'h110, 6);
        add_pkt(2, 16, 12'h220, 16);
        drive();
        run(100);
        check("t_pulses", n_to_p, 1);
        check("t_when", to_iter, 71);
        check("t_ch2_end", last_vld, 88);
        check("t_left", exp_q.size(), 0);

        // Stall of 63 cycles survives
        do_reset();
        add_pkt(1, 6, 12'h110, 6);
        add_idle(1, 63);
        for (int i = 6; i < 16; i++) add_word(1, 14'(12'h110 + i), 1);
        drive();
        run(100);
        check("t63_pulses", n_to_p, 0);
        check("t63_nvld", n_vld, 16);
        check("t63_left", exp_q.size(), 0);

        // Framing: stray word dropped, SoF at word 7, then SoF on the last slot
        do_reset();
        add_word(0, 14'h0055, 0);
        for (int i = 0; i < 23; i++)
            add_word(0, {(i == 0 || i == 7), 1'b0, 12'(12'h500 + i)}, 1);
        for (int i = 0; i < 31; i++)
            add_word(0, {(i == 0 || i == 15), 1'b0, 12'(12'h600 + i)}, 1);
        drive();
        run(75);
        check("f_err", n_err_p, 3);
        check("f_nvld", n_vld, 54);
        check("f_left", exp_q.size(), 0);

        // Tag alignment through the rectifier, overflow flag passes
        do_reset();
        add_word(3, 14'h2F00, 1);
        add_word(3, 14'h1F00, 1);
        add_word(3, 14'h0123, 1);
        for (int i = 3; i < 16; i++) add_word(3, 14'(12'h800 + i), 1);
        drive();
        run(22);
        check("g_nvld", n_vld, 16);
        check("g_left", exp_q.size(), 0);

        // Reset mid-packet, then re-arbitration from pointer 0
        do_reset();
        add_pkt(2, 16, 12'h700, 8);
        add_idle(3, 4);
        add_idle(1, 4);
        add_pkt(1, 16, 12'h180, 16);
        add_pkt(3, 16, 12'h380, 16);
        drive();
        run(9);
        check("r_pre_nvld", n_vld, 8);
        pend_vld = 0;
        i_rstn = 1'b0;
        src_q[2].delete();
        drive();
        @(posedge i_clk);
        #1;
        check("r_valid", o_valid, 1'b0);
        check("r_data", o_data, 14'h0);
        check("r_chan", o_chan, 2'd0);
        check("r_chan_rect", o_chan_rect, 2'd0);
        check("r_busy", o_busy, 1'b0);
        check("r_flags", {o_err, o_timeout}, 2'b00);
        check("r_ready", o_ready, 4'h0);
        i_rstn = 1'b1;
        run(40);
        check("r_nvld", n_vld, 40);
        check("r_left", exp_q.size(), 0);
        check("r_pulses", n_err_p + n_to_p, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_rect_arbiter.md
Name: dsp_rect_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one dsp_rectifier instance between NUM_CH ADC channels.
- Sits between the per-channel ADC packet sources and the rectifier input.
- Grants one channel per packet, forwards its 14-bit words (registered) to the rectifier, and tags them with a channel ID.
- Also provides a tag delayed to align with the rectifier output, detects framing errors and aborts stalled packets by timeout.

Parameters:
- NUM_CH, 4, number of requesting ADC channels (2..16).
- PKT_LEN, 16, words per packet, SoF word included (2..1024).
- TIMEOUT, 64, max consecutive idle cycles allowed mid-packet before abort (>=2).
- RECT_LAT, 1, downstream rectifier latency in cycles, used for o_chan_rect alignment.
- CH_W = max(1, clog2(NUM_CH)), localparam.

Ports:
- i_clk  in  1  100MHz system clock
- i_rstn  in  1  synchronous, active-low reset
- i_data  in  14*NUM_CH  per-channel packet words; channel k at [14k+13:14k]; [13] SoF, [12] overflow, [11:0] data
- i_valid  in  NUM_CH  per-channel word valid
- o_ready  out  NUM_CH  per-channel accept; a word transfers when i_valid[k] && o_ready[k]
- o_data  out  14  word to rectifier
- o_valid  out  1  o_data valid (rectifier has no backpressure)
- o_chan  out  CH_W  source channel of o_data
- o_chan_rect  out  CH_W  o_chan delayed RECT_LAT cycles (aligned with rectifier o_data)
- o_busy  out  1  packet grant active
- o_err  out  1  one-cycle pulse: framing error
- o_timeout  out  1  one-cycle pulse: packet aborted by timeout

Behaviour:
- Reset: all registered outputs are 0, o_ready = 0, state = IDLE, RR pointer = 0, word counter = 0, idle counter = 0, o_chan_rect delay line is 0.
- States: IDLE, GRANT.
- IDLE:
  - A request from channel k is i_valid[k] && i_data[k][13].
  - The RR arbiter picks the first requester starting at ptr, ascending with wrap.
  - On a pick: register grant = k, go to GRANT, set ptr = k+1 (mod NUM_CH).
  - No data is accepted in the arbitration cycle.
  - A channel presenting valid without SoF in IDLE gets o_ready[k] = 1 and its word is dropped; o_err pulses once per dropped word.
- GRANT:
  - o_ready = onehot(grant); all other channels see ready = 0 and hold.
  - Each accepted word registers to o_data with o_valid = 1 and o_chan = grant the next cycle (latency 1).
  - The word counter increments per accepted word. On acceptance of word PKT_LEN-1 (0-based), return to IDLE the following cycle.
  - Net effect: one bubble cycle between packets.
- Mid-packet SoF on the granted channel (counter != 0):
  - The word is forwarded.
  - The counter restarts at 1 (resync).
  - o_err pulses.
  - The grant is kept.
- Timeout:
  - The idle counter increments each GRANT cycle without a transfer and clears on any transfer.
  - When it reaches TIMEOUT: go to IDLE, pulse o_timeout, and send no further words for that packet (truncated).
  - The pointer has already advanced.
- o_busy = (state == GRANT).
- o_valid is 0 on every cycle with no transfer.
- Flags [13:12] pass unmodified.
- o_chan_rect is a RECT_LAT-deep shift register of o_chan. It updates every cycle regardless of o_valid.
- Simultaneous events:
  - If a mid-packet SoF coincides with the last-word count, the SoF resync wins and the packet continues.
  - If a transfer occurs on the same cycle the idle counter would hit TIMEOUT, the transfer wins and the counter clears.
- Reset mid-packet:
  - Immediate return to reset values; the partial packet is lost.
  - No o_err or o_timeout is generated.

Decomposition:
- dsp_pkg holds the shared constants:
  - DSP_WORD_W = 14, DSP_SOF_BIT = 13, DSP_OVF_BIT = 12, DSP_DATA_W = 12.
  - State encodings ST_IDLE and ST_GRANT.
- Sub-module dsp_rr_arbiter (combinational): inputs req[NUM_CH] and ptr; outputs gnt_idx and gnt_any.
- The top level holds the FSM, counters, datapath register and tag delay line.

Test Plan:
- Single channel: ch2 sends a SoF packet of 16 words 0x2001, 0x0002..0x0010 -> o_valid 16 consecutive cycles starting 2 cycles after first i_valid, o_chan = 2, o_busy falls after the last word.
- Contention: ch0, ch1 and ch3 all present SoF at reset release -> grant order 0, 1, 3, 0..., exactly one idle cycle between packets, no words interleaved.
- Stall: ch1 packet halts after word 5 for 64 cycles -> o_timeout pulses once at idle-count 64, state returns to IDLE, the next requester is granted; with the stall at 63 cycles, no timeout occurs.
- Framing: ch0 sends a non-SoF word while IDLE -> dropped with one o_err pulse; a mid-packet SoF at word 7 -> forwarded, o_err pulse, packet then runs 15 more words.
- Tag alignment: with a dsp_rectifier attached (RECT_LAT = 1), ch3 sends 0x0F00 (data -256) -> rectifier outputs 0x0100 on the cycle o_chan_rect = 3; the overflow bit passes through.
- Reset: assert i_rstn low at word 8 of a packet -> all outputs 0 the next cycle; after release, the pending SoF from ptr = 0 order is re-arbitrated.
